// File: rtl/vec_wb_pkg.sv
// Shared types and constants for the Wishbone vector sequencer.
// Imported by the address decoder and the sequencer top.
package vec_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_INSTR,
    ISSUE_LOAD,
    WAIT_STORE,
    ACK
  } state_t;

  localparam logic [4:0]  VLOAD         = 5'b00000;
  localparam logic [4:0]  VSTORE        = 5'b00001;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h3000_0000;
  localparam logic [31:0] SENTINEL      = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational decode of a Wishbone byte address into the
// instruction register or an element-window word index.
module wb_addr_decode
  import vec_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          NUM_ELEMS = 64
) (
  input  logic [31:0] adr,
  output logic        is_instr,
  output logic        is_win,
  output logic [31:0] index
);

  localparam logic [31:0] WIN_LO = BASE_ADDR + 32'd4;
  localparam logic [31:0] WIN_HI = WIN_LO + 32'(4 * NUM_ELEMS);

  logic [31:0] off;

  always_comb begin
    off      = adr - WIN_LO;
    is_instr = (adr == BASE_ADDR);
    is_win   = (adr >= WIN_LO) && (adr < WIN_HI);
    index    = is_win ? (off >> 2) : '0;
  end

endmodule

// File: rtl/wb_vec_sequencer.sv
// Wishbone slave that turns register/window accesses into
// instruction, load and store-return stream beats.
module wb_vec_sequencer
  import vec_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEF,
  parameter int          NUM_ELEMS      = 64,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] instruction_recv_msg,
  output logic        instruction_recv_val,
  input  logic        instruction_recv_rdy,
  output logic [63:0] load_recv_msg,
  output logic        load_recv_val,
  input  logic        load_recv_rdy,
  input  logic [31:0] store_send_msg,
  input  logic        store_send_val,
  output logic        store_send_rdy,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          we_q, win_q, abort_q;
  logic          dec_instr, dec_win;
  logic [31:0]   dec_index;
  logic          req, stop, last;
  logic          unused_sel;

  wb_addr_decode #(
    .BASE_ADDR(BASE_ADDR),
    .NUM_ELEMS(NUM_ELEMS)
  ) u_dec (
    .adr     (wbs_adr_i),
    .is_instr(dec_instr),
    .is_win  (dec_win),
    .index   (dec_index)
  );

  assign unused_sel = ^wbs_sel_i;
  assign req  = wbs_cyc_i & wbs_stb_i;
  assign stop = abort_q | ~wbs_cyc_i;
  assign last = (cnt == CNT_LAST);

  assign instruction_recv_val = (state == ISSUE_INSTR);
  assign load_recv_val        = (state == ISSUE_LOAD);
  assign store_send_rdy       = (state == WAIT_STORE);
  assign busy_o               = (state != IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (dec_instr)
            state_n = wbs_we_i ? ISSUE_INSTR : ACK;
          else if (dec_win)
            state_n = ISSUE_INSTR;
          else
            state_n = ACK;
        end
      end
      ISSUE_INSTR: begin
        if (instruction_recv_rdy)
          state_n = stop ? IDLE : (win_q ? ISSUE_LOAD : ACK);
      end
      ISSUE_LOAD: begin
        if (load_recv_rdy)
          state_n = stop ? IDLE : (we_q ? ACK : WAIT_STORE);
      end
      WAIT_STORE: begin
        if (!wbs_cyc_i)
          state_n = IDLE;
        else if (store_send_val || last)
          state_n = ACK;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state                <= IDLE;
      cnt                  <= '0;
      we_q                 <= 1'b0;
      win_q                <= 1'b0;
      abort_q              <= 1'b0;
      wbs_ack_o            <= 1'b0;
      wbs_dat_o            <= '0;
      instruction_recv_msg <= '0;
      load_recv_msg        <= '0;
      timeout_o            <= 1'b0;
    end else begin
      state     <= state_n;
      wbs_ack_o <= (state_n == ACK);
      cnt       <= (state == WAIT_STORE) ? cnt + 1'b1 : '0;
      // Remember a dropped cycle so the beat in flight still finishes.
      if (state == IDLE)
        abort_q <= 1'b0;
      else if (!wbs_cyc_i &&
               (state == ISSUE_INSTR || state == ISSUE_LOAD))
        abort_q <= 1'b1;
      if (state == IDLE && req) begin
        we_q  <= wbs_we_i;
        win_q <= dec_win;
        instruction_recv_msg <= dec_instr ? wbs_dat_i :
          {(wbs_we_i ? VLOAD : VSTORE), 27'b0};
        load_recv_msg <= {dec_index,
                          (wbs_we_i ? wbs_dat_i : 32'b0)};
        if (!(dec_win || (dec_instr && wbs_we_i)))
          wbs_dat_o <= '0;
      end
      if (state == WAIT_STORE && wbs_cyc_i) begin
        if (store_send_val) begin
          wbs_dat_o <= store_send_msg;
        end else if (last) begin
          wbs_dat_o <= SENTINEL;
          timeout_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_vec_sequencer.sv
// Directed scoreboard bench for wb_vec_sequencer: expected stream
// beats are queued at drive time and checked when the DUT emits them.
module tb_wb_vec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] imsg;
  logic        ival, irdy;
  logic [63:0] lmsg;
  logic        lval, lrdy;
  logic [31:0] smsg;
  logic        sval, srdy;
  logic        busy, tmo;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  bit ack_expected = 1'b0;

  logic [31:0] exp_instr[$];
  logic [63:0] exp_load[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  wb_vec_sequencer dut (
    .wb_clk_i            (clk),
    .wb_rst_ni           (rst_n),
    .wbs_stb_i           (stb),
    .wbs_cyc_i           (cyc),
    .wbs_we_i            (we),
    .wbs_sel_i           (sel),
    .wbs_dat_i           (wdat),
    .wbs_adr_i           (adr),
    .wbs_ack_o           (ack),
    .wbs_dat_o           (rdat),
    .instruction_recv_msg(imsg),
    .instruction_recv_val(ival),
    .instruction_recv_rdy(irdy),
    .load_recv_msg       (lmsg),
    .load_recv_val       (lval),
    .load_recv_rdy       (lrdy),
    .store_send_msg      (smsg),
    .store_send_val      (sval),
    .store_send_rdy      (srdy),
    .busy_o              (busy),
    .timeout_o           (tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        p_ival = 1'b0, p_ihs = 1'b0;
  logic [31:0] p_imsg = '0;

  always @(negedge clk) begin
    if (rst_n && ival && p_ival && !p_ihs)
      chk("instr_msg_stable", {32'b0, imsg}, {32'b0, p_imsg});
    if (rst_n && ival && irdy) begin
      if (exp_instr.size() == 0)
        chk("instr_beat_unexpected", {32'b0, imsg}, 64'hX);
      else
        chk("instr_beat", {32'b0, imsg}, {32'b0, exp_instr.pop_front()});
    end
    p_ival = ival;
    p_ihs  = ival & irdy;
    p_imsg = imsg;
  end

  always @(negedge clk) begin
    if (rst_n && lval && lrdy) begin
      if (exp_load.size() == 0)
        chk("load_beat_unexpected", lmsg, 64'hX);
      else
        chk("load_beat", lmsg, exp_load.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && ack && !ack_expected)
      chk("ack_unexpected", {63'b0, ack}, 64'd0);
  end

  task automatic drive(input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
  endtask

  task automatic release_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_access(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int exp_lat,
                           input logic [31:0] exp_dat,
                           input string tag);
    int c0;
    bit got;
    got = 1'b0;
    @(negedge clk);
    drive(w, a, d);
    c0 = cycle;
    ack_expected = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_ack_seen"}, {63'b0, got}, 64'd1);
    if (got) begin
      chk({tag, "_latency"}, 64'(cycle - c0), 64'(exp_lat));
      chk({tag, "_dat_o"}, {32'b0, rdat}, {32'b0, exp_dat});
    end
    release_bus();
    @(negedge clk);
    ack_expected = 1'b0;
    chk({tag, "_ack_one_cycle"}, {63'b0, ack}, 64'd0);
    chk({tag, "_idle_after"}, {63'b0, busy}, 64'd0);
  endtask

  task automatic store_respond(input int delay, input logic [31:0] d);
    int n;
    n = 0;
    while (!srdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("store_rdy_seen", {63'b0, srdy}, 64'd1);
    repeat (delay) @(negedge clk);
    sval = 1'b1;
    smsg = d;
    @(negedge clk);
    sval = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, {63'b0, ack}, 64'd0);
    chk({tag, "_vals"}, {61'b0, ival, lval, srdy}, 64'd0);
    chk({tag, "_busy_tmo"}, {62'b0, busy, tmo}, 64'd0);
    chk({tag, "_dat_o"}, {32'b0, rdat}, 64'd0);
    chk({tag, "_imsg"}, {32'b0, imsg}, 64'd0);
    chk({tag, "_lmsg"}, lmsg, 64'd0);
  endtask

  initial begin
    int n;
    int acks;
    rst_n = 1'b0;
    release_bus();
    sel = 4'hF; adr = '0; wdat = '0;
    irdy = 1'b1; lrdy = 1'b1; sval = 1'b0; smsg = '0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    exp_instr.push_back(32'h1234_5678);
    wb_access(1'b1, 32'h3000_0000, 32'h1234_5678, 2, 32'h0, "instr_wr");
    chk("instr_wr_drained", 64'(exp_instr.size()), 64'd0);

    exp_instr.push_back({5'b00001, 27'b0});
    exp_load.push_back({32'd1, 32'h0});
    fork
      wb_access(1'b0, 32'h3000_0008, 32'h0, 9, 32'hCAFE_F00D, "win_rd");
      store_respond(5, 32'hCAFE_F00D);
    join
    chk("win_rd_drained", 64'(exp_instr.size() + exp_load.size()), 64'd0);

    exp_instr.push_back({5'b00000, 27'b0});
    exp_load.push_back({32'd2, 32'hAAAA_0001});
    wb_access(1'b1, 32'h3000_000C, 32'hAAAA_0001, 3, 32'hCAFE_F00D,
              "win_wr");

    exp_instr.push_back({5'b00000, 27'b0});
    exp_load.push_back({32'd63, 32'h0000_0063});
    wb_access(1'b1, 32'h3000_0100, 32'h0000_0063, 3, 32'hCAFE_F00D,
              "win_wr_last");
    chk("win_wr_drained", 64'(exp_instr.size() + exp_load.size()), 64'd0);

    wb_access(1'b0, 32'h3000_0000, 32'h0, 1, 32'h0, "instr_rd");

    exp_instr.push_back({5'b00001, 27'b0});
    exp_load.push_back({32'd0, 32'h0});
    fork
      wb_access(1'b0, 32'h3000_0004, 32'h0, 4, 32'h1357_9BDF, "win_rd0");
      store_respond(0, 32'h1357_9BDF);
    join

    wb_access(1'b1, 32'h3000_0104, 32'hFFFF_FFFF, 1, 32'h0, "nop_past_end");
    wb_access(1'b0, 32'h3000_1000, 32'h0, 1, 32'h0, "nop_far");

    exp_instr.push_back({5'b00001, 27'b0});
    exp_load.push_back({32'd5, 32'h0});
    @(negedge clk);
    drive(1'b0, 32'h3000_0018, 32'h0);
    n = 0;
    while (!srdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ws_abort_rdy_seen", {63'b0, srdy}, 64'd1);
    release_bus();
    @(negedge clk);
    chk("ws_abort_idle", {62'b0, busy, srdy}, 64'd0);
    chk("ws_abort_no_tmo", {62'b0, tmo, ack}, 64'd0);

    irdy = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h3000_0000, 32'h5555_AAAA);
    exp_instr.push_back(32'h5555_AAAA);
    repeat (3) @(negedge clk);
    release_bus();
    repeat (7) @(negedge clk);
    chk("stall_val_held", {63'b0, ival}, 64'd1);
    chk("stall_msg", {32'b0, imsg}, {32'b0, 32'h5555_AAAA});
    irdy = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("stall_no_ack", 64'(acks), 64'd0);
    chk("stall_idle", {63'b0, busy}, 64'd0);
    chk("stall_drained", 64'(exp_instr.size()), 64'd0);

    chk("tmo_before", {63'b0, tmo}, 64'd0);
    exp_instr.push_back({5'b00001, 27'b0});
    exp_load.push_back({32'd3, 32'h0});
    wb_access(1'b0, 32'h3000_0010, 32'h0, 258, 32'hDEAD_BEEF, "timeout");
    chk("tmo_flag", {63'b0, tmo}, 64'd1);

    lrdy = 1'b0;
    exp_instr.push_back({5'b00000, 27'b0});
    @(negedge clk);
    drive(1'b1, 32'h3000_0014, 32'h0BAD_CAFE);
    n = 0;
    while (!lval && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_load_val", {63'b0, lval}, 64'd1);
    chk("rst_mid_load_msg", lmsg, {32'd4, 32'h0BAD_CAFE});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    release_bus();
    lrdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wb_access(1'b0, 32'h3000_0000, 32'h0, 1, 32'h0, "post_reset");
    chk("final_queues", 64'(exp_instr.size() + exp_load.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
